lstm_weight_deserializer: RTL and testbench
===========================================

Name: lstm_weight_deserializer

Overview:
- Serial-to-parallel converter between a systolic weight array and the LSTM cell.
- Each frame of M serial words starts with a start pulse. The frame carries lead-in words, which are discarded, followed by 2*FEATURES payload words.
- The first FEATURES payload words are packed into parallel_data_out_1 and the next FEATURES into parallel_data_out_2. done is then raised.
- Two instances run in parallel, one per gate-pair array (i/g and f/o).

Parameters:
ELEMENT_BITS, 8, width of one serial word / vector element
FEATURES, 4, elements per parallel output vector
FEATURE_BITS, 4, width of the internal word counter; must satisfy 2^FEATURE_BITS >= M
M, 9, serial words per frame including lead-in; M >= 2*FEATURES; lead-in L = M - 2*FEATURES (default 1)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  single-cycle pulse; the cycle it is high carries frame word 0
serial_data_in  in  ELEMENT_BITS  one frame word per cycle
parallel_data_out_1  out  FEATURES*ELEMENT_BITS  payload words 0..FEATURES-1
parallel_data_out_2  out  FEATURES*ELEMENT_BITS  payload words FEATURES..2*FEATURES-1
done  out  1  frame complete, outputs valid

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - State goes to IDLE; counter=0.
  - Internal buffer, both outputs and done go to 0.
  - Reset overrides all other inputs and aborts any frame in progress.
- States:
  - IDLE, CAPTURE, DONE.
  - IDLE, start=1: word 0 is consumed (index 0), counter=1, go to CAPTURE. start=0: stay.
  - CAPTURE: one word is consumed every cycle; start is ignored.
  - CAPTURE, final word (index M-1) consumed: go to DONE.
  - DONE: done=1 and outputs hold. start=1 begins a new frame exactly as from IDLE, and done falls at that edge.
- Word mapping:
  - Word index k with k >= L gives payload p = k - L.
  - p < FEATURES: stored at out_1 bits [(p+1)*ELEMENT_BITS-1 : p*ELEMENT_BITS].
  - Otherwise: stored at out_2 slot p - FEATURES.
  - Words with k < L are discarded.
- Output update is atomic:
  - Payload accumulates in an internal buffer.
  - On the edge that consumes word M-1, both outputs load buffer plus the final word, and done rises on that same edge.
  - With start in cycle t, done and new outputs are first visible in cycle t+M.
  - Outputs never show a partially filled frame; previous frame values persist until the next frame completes.
- done is a level: it stays high in DONE until reset or a new start.
- The path is pure data movement, with no arithmetic or sign handling.
- Degenerate case L=0: payload starts at word 0.

Optional Feature:
- Macro: DESER_REVERSE_ORDER_EN.
- Defined: payload order is reversed. Payload p maps to reversed index q = 2*FEATURES-1-p, and q is placed using the normal rule. So p=0 lands in the top slot of out_2, and p=2F-1 lands in slot 0 of out_1.
- Undefined: the normal mapping above applies.
- Timing, done and lead-in handling are identical in both modes.

Test Plan (defaults: ELEMENT_BITS=8, FEATURES=4, M=9):
- Reset: hold reset_n=0 for 2 cycles -> out_1=0, out_2=0, done=0.
- Basic frame: start at cycle t with words 0xFF,0x01..0x08 on t..t+8 -> at t+9 out_1=0x04030201, out_2=0x08070605, done=1; done=0 and outputs unchanged during t..t+8.
- Start during capture: extra start pulse at t+3 -> ignored; same result at t+9.
- Back-to-back frames: new start while done=1, words 0xAA,0x11..0x88 -> done falls next cycle; old outputs held until new done, then out_1=0x44332211, out_2=0x88776655.
- Mid-frame reset: reset_n=0 at t+5 -> outputs 0, done 0; a subsequent full frame completes normally.
- Macro DESER_REVERSE_ORDER_EN defined, basic-frame stimulus -> out_1=0x05060708, out_2=0x01020304.

Source files
------------

// File: rtl/lstm_weight_deserializer.sv
// Serial-to-parallel weight deserializer: one frame of M words -> two packed vectors plus done.
// Optional macro DESER_REVERSE_ORDER_EN reverses the payload order across both output vectors.
module lstm_weight_deserializer #(
  parameter int ELEMENT_BITS = 8,
  parameter int FEATURES     = 4,
  parameter int FEATURE_BITS = 4,
  parameter int M            = 9
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [ELEMENT_BITS-1:0]          serial_data_in,
  output logic [FEATURES*ELEMENT_BITS-1:0] parallel_data_out_1,
  output logic [FEATURES*ELEMENT_BITS-1:0] parallel_data_out_2,
  output logic                             done
);

  localparam int L     = M - 2*FEATURES;
  localparam int VEC_W = FEATURES*ELEMENT_BITS;
  localparam int SLOTS = 2*FEATURES;

  localparam logic [FEATURE_BITS-1:0] LEAD     = FEATURE_BITS'(L);
  localparam logic [FEATURE_BITS-1:0] LAST     = FEATURE_BITS'(M-1);
  localparam logic [FEATURE_BITS-1:0] TOP_SLOT = FEATURE_BITS'(SLOTS-1);

  if (M < 2*FEATURES) begin : g_bad_m
    $error("M must be at least 2*FEATURES");
  end
  if ((2**FEATURE_BITS) < M) begin : g_bad_cnt
    $error("FEATURE_BITS too narrow to index M words");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [FEATURE_BITS-1:0]   cnt_q;
  logic [FEATURE_BITS-1:0]   cnt_d;
  logic [2*VEC_W-1:0]        frame_q;
  logic [2*VEC_W-1:0]        frame_d;
  logic                      consume;
  logic                      last_word;
  logic [FEATURE_BITS-1:0]   word_idx;

  // Buffer slot for a frame word index; slots 0..F-1 feed out_1, F..2F-1 feed out_2.
  function automatic logic [FEATURE_BITS-1:0] slot_of(input logic [FEATURE_BITS-1:0] k);
    logic [FEATURE_BITS-1:0] p;
    p = k - LEAD;
`ifdef DESER_REVERSE_ORDER_EN
    return TOP_SLOT - p;
`else
    return p;
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    consume   = 1'b0;
    last_word = 1'b0;
    word_idx  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          consume  = 1'b1;
          word_idx = '0;
          cnt_d    = FEATURE_BITS'(1);
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        consume  = 1'b1;
        word_idx = cnt_q;
        cnt_d    = cnt_q + FEATURE_BITS'(1);
        if (cnt_q == LAST) begin
          last_word = 1'b1;
          cnt_d     = '0;
          state_d   = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Lead-in words are dropped; payload words land in their slot of the staging buffer.
  always_comb begin
    frame_d = frame_q;
    if (consume && (word_idx >= LEAD)) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (slot_of(word_idx) == FEATURE_BITS'(s)) begin
          frame_d[s*ELEMENT_BITS +: ELEMENT_BITS] = serial_data_in;
        end
      end
    end
  end

  // Outputs load only on the final word, so a partial frame is never exposed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q             <= S_IDLE;
      cnt_q               <= '0;
      frame_q             <= '0;
      parallel_data_out_1 <= '0;
      parallel_data_out_2 <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      if (last_word) begin
        parallel_data_out_1 <= frame_d[VEC_W-1:0];
        parallel_data_out_2 <= frame_d[2*VEC_W-1:VEC_W];
      end
    end
  end

  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_lstm_weight_deserializer.sv
// Scoreboard bench for lstm_weight_deserializer (ELEMENT_BITS=8, FEATURES=4, M=9).
module tb_lstm_weight_deserializer;

  localparam int EB = 8;
  localparam int F  = 4;
  localparam int FB = 4;
  localparam int MW = 9;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [EB-1:0]   serial_data_in;
  logic [F*EB-1:0] parallel_data_out_1;
  logic [F*EB-1:0] parallel_data_out_2;
  logic            done;

  lstm_weight_deserializer #(
    .ELEMENT_BITS(EB),
    .FEATURES    (F),
    .FEATURE_BITS(FB),
    .M           (MW)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .serial_data_in     (serial_data_in),
    .parallel_data_out_1(parallel_data_out_1),
    .parallel_data_out_2(parallel_data_out_2),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [F*EB-1:0] o1;
    logic [F*EB-1:0] o2;
    int              cyc;
  } exp_t;

  exp_t            sb_q[$];
  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;
  logic            mon_en = 1'b0;
  logic            exp_done = 1'b0;
  logic            done_d = 1'b0;
  logic [F*EB-1:0] held1 = '0;
  logic [F*EB-1:0] held2 = '0;

  localparam logic [MW*EB-1:0] FRAME_A = 72'h08_07_06_05_04_03_02_01_FF;
  localparam logic [MW*EB-1:0] FRAME_B = 72'h88_77_66_55_44_33_22_11_AA;
`ifdef DESER_REVERSE_ORDER_EN
  localparam logic [F*EB-1:0] A1 = 32'h05060708;
  localparam logic [F*EB-1:0] A2 = 32'h01020304;
  localparam logic [F*EB-1:0] B1 = 32'h55667788;
  localparam logic [F*EB-1:0] B2 = 32'h11223344;
`else
  localparam logic [F*EB-1:0] A1 = 32'h04030201;
  localparam logic [F*EB-1:0] A2 = 32'h08070605;
  localparam logic [F*EB-1:0] B1 = 32'h44332211;
  localparam logic [F*EB-1:0] B2 = 32'h88776655;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on each rising done, otherwise expects held outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (done !== exp_done) begin
        bad++;
        $display("FAIL done_level cyc=%0d got=%b want=%b", cyc, done, exp_done);
      end
      if (done && !done_d) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_done cyc=%0d got=done want=no_done", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (cyc != e.cyc) begin
            bad++;
            $display("FAIL done_latency got_cyc=%0d want_cyc=%0d", cyc, e.cyc);
          end
          held1 = e.o1;
          held2 = e.o2;
        end
      end else if (sb_q.size() > 0 && cyc >= sb_q[0].cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        total++;
        bad++;
        $display("FAIL missing_done cyc=%0d got=no_done want_cyc=%0d", cyc, e.cyc);
        held1 = e.o1;
        held2 = e.o2;
      end
      total++;
      if (parallel_data_out_1 !== held1) begin
        bad++;
        $display("FAIL out_1 cyc=%0d got=%h want=%h", cyc, parallel_data_out_1, held1);
      end
      total++;
      if (parallel_data_out_2 !== held2) begin
        bad++;
        $display("FAIL out_2 cyc=%0d got=%h want=%h", cyc, parallel_data_out_2, held2);
      end
      done_d = done;
    end
  end

  task automatic idle(input int n);
    start          = 1'b0;
    serial_data_in = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; extra_start re-pulses start mid-frame, rst_at aborts with reset at that word.
  task automatic send_frame(input logic [MW*EB-1:0] words, input int extra_start,
                            input int rst_at, input logic [F*EB-1:0] e1,
                            input logic [F*EB-1:0] e2);
    for (int i = 0; i < MW; i++) begin
      if (i == rst_at) begin
        reset_n        = 1'b0;
        start          = 1'b0;
        serial_data_in = '0;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        held1    = '0;
        held2    = '0;
        exp_done = 1'b0;
        return;
      end
      start          = (i == 0) || (i == extra_start);
      serial_data_in = words[i*EB +: EB];
      @(posedge clk);
      #1;
      if (i == 0) exp_done = 1'b0;
      if (i == MW-1) begin
        exp_t e;
        e.o1  = e1;
        e.o2  = e2;
        e.cyc = cyc;
        sb_q.push_back(e);
        exp_done = 1'b1;
      end
    end
    start          = 1'b0;
    serial_data_in = '0;
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    serial_data_in = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    send_frame(FRAME_A, -1, -1, A1, A2);
    idle(3);
    send_frame(FRAME_A, 3, -1, A1, A2);
    send_frame(FRAME_B, -1, -1, B1, B2);
    idle(2);
    send_frame(FRAME_A, -1, 5, A1, A2);
    idle(2);
    send_frame(FRAME_A, -1, -1, A1, A2);
    idle(3);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
